// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between the core's memory port and
// data_mem_responder. The core drives the master side; the responder is the slave.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding byte/half/word memory responder.
// Handles lane alignment, byte-enable stores and load sign/zero extension over
// a word-organised array, with LATENCY (1..15) cycles from accept to response.
// Optional statistics counters are built only when DMEM_STATS_EN is defined;
// otherwise ld_count/st_count/err_count are tied to zero.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus,
    output logic [31:0]           ld_count,
    output logic [31:0]           st_count,
    output logic [31:0]           err_count
);
    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          do_exec;
    logic          err_c;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   word_rd, shifted, ld_data;

    assign idx     = addr_q[AW+1:2];
    assign do_exec = (state == BUSY) && (cnt == 4'd0);
    assign word_rd = mem[idx];
    assign shifted = word_rd >> {addr_q[1:0], 3'b000};

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Error check, store lane enables/replicated data, and load formatting
    always_comb begin
        err_c   = (size_q == 2'b11)
                | ((size_q == 2'b01) && addr_q[0])
                | ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
                | ({1'b0, addr_q} >= ADDR_LIMIT);
        be      = 4'b0000;
        wd      = wdata_q;
        ld_data = 32'd0;
        case (size_q)
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                wd      = {4{wdata_q[7:0]}};
                ld_data = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wd      = {2{wdata_q[15:0]}};
                ld_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                be      = 4'b1111;
                ld_data = word_rd;
            end
            default: ;
        endcase
    end

    // Control FSM: capture on accept, count down latency, register response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    uns_q   <= bus.req_unsigned;
                    size_q  <= bus.req_size;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    cnt     <= 4'(LATENCY - 1);
                    state   <= BUSY;
                end
                BUSY: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    err_q   <= err_c;
                    rdata_q <= (err_c || we_q) ? 32'd0 : ld_data;
                    state   <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-enable array write; an async reset forces IDLE so a pending store never lands
    always_ff @(posedge clk) begin
        if (do_exec && we_q && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating statistics, bumped on the same edge the response registers load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_count  <= 32'd0;
            st_count  <= 32'd0;
            err_count <= 32'd0;
        end else if (do_exec) begin
            if (err_c) begin
                if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
            end else if (we_q) begin
                if (st_count != 32'hFFFF_FFFF) st_count <= st_count + 32'd1;
            end else begin
                if (ld_count != 32'hFFFF_FFFF) ld_count <= ld_count + 32'd1;
            end
        end
    end
`else
    assign ld_count  = 32'd0;
    assign st_count  = 32'd0;
    assign err_count = 32'd0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=3, DEPTH_WORDS=1024).
// Vector table for load/store formatting and error cases, plus hand-written
// sequences for handshake timing, reset mid-BUSY/RESP and statistics.
module tb_data_mem_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ld_count, st_count, err_count;
    int          tests = 0;
    int          fails = 0;
    int          ld_m = 0, st_m = 0, err_m = 0;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ld_count(ld_count), .st_count(st_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output logic got);
        int n;
        got = 1'b0;
        rd  = 32'hx;
        er  = 1'bx;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.rsp_valid) begin
                got = 1'b1;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, got;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h000000DE, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'h0000DEAD, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h12,   32'hAAAA1234, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h1234BEEF, 1'b0};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h11,   32'hFFFFFF55, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h123455EF, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h12,   32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h123455EF, 1'b0};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h20,   32'h11223344, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h20,   32'h0,        32'h00000044, 1'b0};
        vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h22,   32'h0,        32'h00001122, 1'b0};
        vecs[17] = '{1'b1, 2'b10, 1'b0, 32'hFFC,  32'h80000001, 32'h0,        1'b0};
        vecs[18] = '{1'b0, 2'b01, 1'b0, 32'hFFE,  32'h0,        32'hFFFF8000, 1'b0};
        vecs[19] = '{1'b0, 2'b00, 1'b1, 32'hFFF,  32'h0,        32'h00000080, 1'b0};
        vecs[20] = '{1'b0, 2'b10, 1'b1, 32'hFFC,  32'h0,        32'h80000001, 1'b0};
        vecs[21] = '{1'b1, 2'b00, 1'b0, 32'h1003, 32'h77,       32'h0,        1'b1};

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset rsp_err",   32'(bus.rsp_err), 32'd0);
        check("reset ld_count",  ld_count, 32'd0);
        check("reset st_count",  st_count, 32'd0);
        check("reset err_count", err_count, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            xact(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, got);
            check($sformatf("vec%0d response seen", i), 32'(got), 32'd1);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) err_m++;
            else if (vecs[i].we) st_m++;
            else ld_m++;
        end

        // Accept at edge 0 with req_valid held through BUSY; response after edge 3 only
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        @(negedge clk);  // edge 0
        check("lat e0 ready", 32'(bus.req_ready), 32'd0);
        check("lat e0 valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);  // edge 1
        check("lat e1 valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);  // edge 2
        check("lat e2 valid", 32'(bus.rsp_valid), 32'd0);
        check("lat e2 ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);  // edge 3
        check("lat e3 valid", 32'(bus.rsp_valid), 32'd1);
        check("lat e3 ready", 32'(bus.req_ready), 32'd0);
        check("lat e3 rdata", bus.rsp_rdata, 32'h123455EF);
        @(negedge clk);  // edge 4
        check("lat e4 valid", 32'(bus.rsp_valid), 32'd0);
        check("lat e4 ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);  // edge 5: nothing was queued from the held valid
        check("lat e5 valid", 32'(bus.rsp_valid), 32'd0);
        check("lat e5 ready", 32'(bus.req_ready), 32'd1);
        ld_m++;

`ifdef DMEM_STATS_EN
        check("stats ld_count",  ld_count,  32'(ld_m));
        check("stats st_count",  st_count,  32'(st_m));
        check("stats err_count", err_count, 32'(err_m));
`else
        check("stats ld_count off",  ld_count,  32'd0);
        check("stats st_count off",  st_count,  32'd0);
        check("stats err_count off", err_count, 32'd0);
`endif

        // Store accepted, reset mid-BUSY: store dropped, outputs at reset values
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst busy ready", 32'(bus.req_ready), 32'd1);
        check("rst busy valid", 32'(bus.rsp_valid), 32'd0);
        check("rst busy rdata", bus.rsp_rdata, 32'd0);
        check("rst busy err",   32'(bus.rsp_err), 32'd0);
        check("rst busy ld_count", ld_count, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, got);
        check("after rst response seen", 32'(got), 32'd1);
        check("after rst lw 0x20", rd, 32'h11223344);
        check("after rst err", 32'(er), 32'd0);

        // Reset asserted while in RESP drops rsp_valid at once
        xact(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, rd, er, got);
        check("resp rst seen", 32'(got), 32'd1);
        check("resp rst rdata", rd, 32'h00000011);
        #1;
        rst = 1'b0;
        #1;
        check("resp rst valid", 32'(bus.rsp_valid), 32'd0);
        check("resp rst ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
